binary_counter_scheduler: RTL
=============================

# binary_counter_scheduler

Round-robin scheduler that shares one external modulo-MOD Moore binary counter between N requesters. It grants exclusive ownership of the counter's count-enable input to one requester at a time. It releases ownership when the shared counter wraps or when the owner withdraws. It keeps a shadow copy of the counter state and checks it against the counter's terminal-count output.

## Interface
- N, default 4: number of requesters, N >= 2.
- MOD, default 4: counter modulus, MOD >= 2. Must equal the external counter's state count.
- rstn  input  1  asynchronous active-low reset.
- clk  input  1  rising-edge clock.
- req_in  input  N  request level per requester; held while ownership is wanted.
- inc_in  input  N  increment strobe per requester; only the owner's bit is honoured.
- y_in  input  1  terminal-count output of the external counter (high in the last state, MOD-1).
- x_out  output  1  count enable to the external counter; combinational.
- gnt_out  output  N  one-hot grant, registered.
- done_out  output  N  one-cycle pulse to the owner whose ownership ended in a counter wrap.
- busy_out  output  1  high when state is not IDLE.
- err_out  output  1  sticky shadow/terminal-count mismatch flag.

## Operation
- Shared context: the external counter runs on the same clk/rstn, with its x_in driven by x_out.
- Internal registers:
  - state: IDLE, OWN or REL.
  - owner: $clog2(N) bits.
  - ptr: $clog2(N) bits, next round-robin start.
  - shadow: $clog2(MOD) bits.
  - err.
- IDLE:
  - gnt_out=0, x_out=0.
  - If req_in is nonzero: winner = first index i with req_in[i]=1, searching ptr, ptr+1, … with wrap mod N.
  - Next edge: owner=winner, gnt_out=onehot(winner), state=OWN.
  - If req_in=0: remain in IDLE.
- OWN:
  - x_out = inc_in[owner]. inc_in from non-owners is ignored.
  - When x_out=1: shadow <= shadow+1, wrapping MOD-1 -> 0.
  - Wrap (x_out=1 and shadow=MOD-1): next edge state=REL, gnt_out=0, done_out[owner]=1.
  - Otherwise, if req_in[owner]=0: next edge state=REL, gnt_out=0, done_out=0. An increment in the same cycle still counts.
  - Wrap and request withdrawal in the same cycle: the wrap takes priority, so done pulses.
  - Otherwise: stay in OWN with the grant held.
- REL:
  - Lasts exactly one cycle. gnt_out=0, x_out=0, done_out as set on entry.
  - Next edge: ptr=(owner+1) mod N, done_out=0, state=IDLE.
- shadow is never cleared except by reset. It persists across owners because the counter is shared.
- err check:
  - Every cycle, compare (shadow==MOD-1) against y_in.
  - Any mismatch sets err on the next edge. err clears only on reset.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, owner=0, ptr=0, shadow=0, err=0.
  - gnt_out=0, done_out=0, busy_out=0, x_out=0.
- Grant latency: req_in seen in IDLE at cycle t -> gnt_out at t+1.
- Increment path: inc_in to x_out is zero-cycle combinational. The counter and shadow update at the following edge.
- Turnaround: after the last OWN cycle, there is one REL cycle and at least one IDLE cycle before the next gnt_out. Minimum grant gap is 2 cycles.
- done_out: registered, high only during the REL cycle.
- gnt_out: at most one bit high. Never high outside OWN.
- Reset mid-OWN: gnt_out drops immediately and shadow returns to 0. The external counter resets to S0 on the same rstn, so no err results.
- req_in changes while in REL: no effect until IDLE.

## Test plan
- Reset values: assert rstn=0 mid-run with arbitrary inputs. Require all outputs 0 asynchronously and shadow=0; after release, state IDLE.
- Single requester, N=4, MOD=4:
  - req_in=0001 -> gnt_out=0001 next cycle.
  - Four inc_in[0] strobes -> x_out pulses 4 times, y_in rises after the 3rd.
  - The edge after the 4th strobe -> gnt_out=0, done_out=0001 for one cycle; err stays 0.
- Round robin: req_in=1111 held, each owner completes a wrap. Require grant order 0,1,2,3,0, with a 2-cycle gap between grants.
- Withdrawal: owner 2 drops req after 2 increments.
  - Require done_out=0 and release via REL.
  - The next owner's first 2 strobes bring shadow to 0 via 2 -> 3 -> 0, and that owner gets done_out.
- Isolation: in OWN with owner 1, strobe inc_in=1101. Require x_out=0 and shadow unchanged.
- Checker: force y_in=1 while shadow=0. Require err_out=1 from the next cycle onward, held until rstn.

Source files
------------

// File: rtl/binary_counter_scheduler.sv
// binary_counter_scheduler
// Round-robin owner arbitration for one shared modulo-MOD counter.
// Ports:
//   clk, rstn   clock / async active-low reset
//   req_in[N]   request levels, held while ownership is wanted
//   inc_in[N]   increment strobes, only the owner's bit is used
//   y_in        terminal-count output of the external counter
//   x_out       count enable to the external counter (combinational)
//   gnt_out[N]  registered one-hot grant
//   done_out[N] one-cycle pulse to an owner released by a counter wrap
//   busy_out    scheduler not idle
//   err_out     sticky shadow vs terminal-count mismatch
module binary_counter_scheduler #(
  parameter int N   = 4,
  parameter int MOD = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] inc_in,
  input  logic         y_in,
  output logic         x_out,
  output logic [N-1:0] gnt_out,
  output logic [N-1:0] done_out,
  output logic         busy_out,
  output logic         err_out
);
  localparam int OW = $clog2(N);
  localparam int SW = $clog2(MOD);

  typedef enum logic [1:0] {IDLE, OWN, REL} state_t;

  state_t         state;
  logic [OW-1:0]  owner;
  logic [OW-1:0]  ptr;
  logic [SW-1:0]  shadow;
  logic           err;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;

  logic           found;
  logic [OW-1:0]  winner;
  logic           shadow_last;
  logic           wrap;

  // Rotating priority search: first requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!found && req_in[j]) begin
        found  = 1'b1;
        winner = OW'(j);
      end
    end
  end

  assign shadow_last = (shadow == SW'(MOD - 1));
  assign x_out       = (state == OWN) && inc_in[owner];
  assign wrap        = x_out && shadow_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= '0;
      shadow <= '0;
      err    <= 1'b0;
      gnt    <= '0;
      done   <= '0;
    end else begin
      // Shadow tracks the shared counter, so it is never cleared between owners.
      err <= err | (shadow_last != y_in);
      if (x_out)
        shadow <= shadow_last ? '0 : shadow + 1'b1;

      case (state)
        IDLE: begin
          if (found) begin
            owner <= winner;
            gnt   <= N'(1) << winner;
            state <= OWN;
          end
        end
        OWN: begin
          // Wrap wins over a simultaneous withdrawal so the owner still sees done.
          if (wrap) begin
            state <= REL;
            gnt   <= '0;
            done  <= N'(1) << owner;
          end else if (!req_in[owner]) begin
            state <= REL;
            gnt   <= '0;
          end
        end
        REL: begin
          ptr   <= (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
          done  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_out  = gnt;
  assign done_out = done;
  assign busy_out = (state != IDLE);
  assign err_out  = err;

endmodule
